otter_hazard_scoreboard: RTL and testbench
==========================================

Name: otter_hazard_scoreboard

Overview:
- Parametrised hazard and forwarding controller for the pipelined OTTER.
- Tracks the destination register of every in-flight instruction downstream of decode in a STAGES-deep shift scoreboard.
- From that state it generates the decode stall, per-operand forwarding selects, and a saturating stall counter.
- Replaces fixed two-deep stall-only hazard tracking; supports a stall-only mode and a forwarding mode with a configurable load latency.

Parameters:
STAGES, 3, in-flight stages tracked after decode; entry 0 = execute, entry STAGES-1 = writeback
REG_AW, 5, register address width
FWD_EN, 1, 1 = forwarding mode; 0 = stall-only mode
LOAD_LAT, 2, first entry index whose load result is forwardable; range 1..STAGES
CNT_W, 16, stall counter width
SEL_W, $clog2(STAGES+1), forwarding select width (derived)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  synchronous active-high reset
DEC_VALID  in  1  decode stage holds a valid instruction
DEC_RS1  in  REG_AW  source register 1 of decode instruction
DEC_RS2  in  REG_AW  source register 2
DEC_USES_RS1  in  1  instruction reads rs1
DEC_USES_RS2  in  1  instruction reads rs2
DEC_RD  in  REG_AW  destination register
DEC_RD_WE  in  1  instruction writes rd
DEC_IS_LOAD  in  1  instruction is a load
FLUSH  in  1  taken branch/jump; kill the decode instruction
STALL  out  1  hold PC and decode register; insert bubble into execute
ISSUE  out  1  decode instruction enters execute this cycle
FWD_A_SEL  out  SEL_W  rs1 source: 0 = register file, k+1 = scoreboard entry k
FWD_B_SEL  out  SEL_W  rs2 source, same encoding
STALL_CNT  out  CNT_W  saturating count of stall cycles

Behaviour:
- Scoreboard entry fields: {valid, rd, we, load}.
- Every rising edge: entry k+1 <= entry k for all k. Entry 0 <= decode fields when ISSUE=1, else a bubble (valid=0). Entries never hold; the pipeline stalls only at decode.
- Match(s,k) = entry k valid & we & rd != 0 & rd == DEC_RSs & DEC_USES_RSs & DEC_VALID. Register x0 never causes a hazard.
- Stall-only mode (FWD_EN=0):
  - STALL = any Match in any entry, including writeback. The register file write lands at the edge, so a decode read in the same cycle is stale.
  - FWD_x_SEL is always 0.
- Forwarding mode (FWD_EN=1):
  - STALL = any Match(s,k) with entry k load=1 and k < LOAD_LAT.
  - Otherwise FWD_x_SEL = k+1 for the lowest-index (youngest) matching k; 0 if no match.
  - Selects are don't-care while STALL=1 but must still follow the same rule.
- ISSUE = DEC_VALID & ~STALL & ~FLUSH.
- FLUSH has priority over STALL:
  - When FLUSH=1, entry 0 receives a bubble.
  - Older entries shift normally.
  - STALL is still reported combinationally.
- STALL, ISSUE and FWD selects are combinational from the scoreboard and decode inputs, with zero latency.
- STALL_CNT increments on every edge where STALL=1 and FLUSH=0. It holds at 2^CNT_W-1.
- Reset:
  - At the edge with RST=1, all entries are cleared to invalid and STALL_CNT is set to 0, regardless of STALL or FLUSH.
  - After reset: STALL=0, FWD selects=0, ISSUE=DEC_VALID & ~FLUSH.
  - Reset mid-stall discards all in-flight state; no stale hazard survives.
- Entries with we=0 (stores, branches) are tracked but never match.

Test Plan:
- FWD_EN=1: "add x5,.." issued, then "sub x6,x5,x1" in decode next cycle -> STALL=0, FWD_A_SEL=1, FWD_B_SEL=0. One cycle later an independent reader of x5 -> FWD_A_SEL=2.
- FWD_EN=1, LOAD_LAT=2: "lw x7" issued, then "add x8,x7,x7" -> STALL=1 for exactly 2 cycles with bubbles in entry 0. Third cycle: STALL=0, FWD_A_SEL=FWD_B_SEL=3, ISSUE=1. STALL_CNT=2.
- FWD_EN=0, STAGES=3: producer of x3 followed by a consumer -> 3 stall cycles, then issue with FWD selects 0. STALL_CNT=3.
- Writer of x0 followed by a reader of x0 -> no stall, selects 0, in both modes.
- Consumer stalled on a load while FLUSH=1 -> ISSUE=0, entry 0 bubble, STALL_CNT unchanged. Next cycle with DEC_VALID=0 -> STALL=0.
- CNT_W=2 with a 5-cycle forced stall -> STALL_CNT sequence 1,2,3,3,3. RST=1 mid-stall -> next cycle all entries invalid, STALL=0, STALL_CNT=0.

Source files
------------

// File: rtl/otter_hazard_scoreboard.sv
// otter_hazard_scoreboard
// Hazard and forwarding controller for the pipelined OTTER. A STAGES-deep
// shift scoreboard records the destination of every instruction past decode
// (entry 0 = execute, entry STAGES-1 = writeback). From it the block derives
// the decode stall, per-operand forwarding selects and a saturating count of
// stall cycles. Stall/issue/select outputs are combinational so the pipeline
// sees them in the same cycle the dependent instruction sits in decode.
module otter_hazard_scoreboard #(
  parameter int STAGES   = 3,
  parameter int REG_AW   = 5,
  parameter int FWD_EN   = 1,
  parameter int LOAD_LAT = 2,
  parameter int CNT_W    = 16,
  parameter int SEL_W    = $clog2(STAGES + 1)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              DEC_VALID,
  input  logic [REG_AW-1:0] DEC_RS1,
  input  logic [REG_AW-1:0] DEC_RS2,
  input  logic              DEC_USES_RS1,
  input  logic              DEC_USES_RS2,
  input  logic [REG_AW-1:0] DEC_RD,
  input  logic              DEC_RD_WE,
  input  logic              DEC_IS_LOAD,
  input  logic              FLUSH,
  output logic              STALL,
  output logic              ISSUE,
  output logic [SEL_W-1:0]  FWD_A_SEL,
  output logic [SEL_W-1:0]  FWD_B_SEL,
  output logic [CNT_W-1:0]  STALL_CNT
);

  localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [REG_AW-1:0] REG_X0  = {REG_AW{1'b0}};

  // Scoreboard entry fields, one bit/field per in-flight stage
  logic [STAGES-1:0] valid_r;
  logic [STAGES-1:0] we_r;
  logic [STAGES-1:0] load_r;
  logic [REG_AW-1:0] rd_r [STAGES];
  logic [CNT_W-1:0]  cnt_r;

  logic [STAGES-1:0] match_a_s;
  logic [STAGES-1:0] match_b_s;
  logic              stall_s;
  logic              issue_s;
  logic [SEL_W-1:0]  sel_a_s;
  logic [SEL_W-1:0]  sel_b_s;

  // Per-entry operand match; x0 and non-writing entries never match
  always_comb begin
    match_a_s = {STAGES{1'b0}};
    match_b_s = {STAGES{1'b0}};
    for (int k = 0; k < STAGES; k++) begin
      match_a_s[k] = valid_r[k] & we_r[k] & (rd_r[k] != REG_X0) &
                     (rd_r[k] == DEC_RS1) & DEC_USES_RS1 & DEC_VALID;
      match_b_s[k] = valid_r[k] & we_r[k] & (rd_r[k] != REG_X0) &
                     (rd_r[k] == DEC_RS2) & DEC_USES_RS2 & DEC_VALID;
    end
  end

  // Stall decision: any match in stall-only mode, only too-young loads when forwarding
  always_comb begin
    stall_s = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      if (FWD_EN == 0) begin
        stall_s = stall_s | match_a_s[k] | match_b_s[k];
      end else begin
        stall_s = stall_s | ((match_a_s[k] | match_b_s[k]) & load_r[k] & (k < LOAD_LAT));
      end
    end
  end

  // Forwarding selects: scan oldest to youngest so the youngest match wins
  always_comb begin
    sel_a_s = {SEL_W{1'b0}};
    sel_b_s = {SEL_W{1'b0}};
    for (int k = STAGES - 1; k >= 0; k--) begin
      if ((FWD_EN != 0) && match_a_s[k]) begin
        sel_a_s = SEL_W'(k + 1);
      end else begin
        sel_a_s = sel_a_s;
      end
      if ((FWD_EN != 0) && match_b_s[k]) begin
        sel_b_s = SEL_W'(k + 1);
      end else begin
        sel_b_s = sel_b_s;
      end
    end
  end

  assign issue_s   = DEC_VALID & ~stall_s & ~FLUSH;
  assign STALL     = stall_s;
  assign ISSUE     = issue_s;
  assign FWD_A_SEL = sel_a_s;
  assign FWD_B_SEL = sel_b_s;
  assign STALL_CNT = cnt_r;

  // Scoreboard shift: entries always advance; entry 0 takes the issued instruction or a bubble
  always_ff @(posedge CLK) begin
    if (RST) begin
      valid_r <= {STAGES{1'b0}};
      we_r    <= {STAGES{1'b0}};
      load_r  <= {STAGES{1'b0}};
      for (int k = 0; k < STAGES; k++) begin
        rd_r[k] <= REG_X0;
      end
    end else begin
      for (int k = 1; k < STAGES; k++) begin
        valid_r[k] <= valid_r[k-1];
        we_r[k]    <= we_r[k-1];
        load_r[k]  <= load_r[k-1];
        rd_r[k]    <= rd_r[k-1];
      end
      valid_r[0] <= issue_s;
      we_r[0]    <= DEC_RD_WE;
      load_r[0]  <= DEC_IS_LOAD;
      rd_r[0]    <= DEC_RD;
    end
  end

  // Saturating stall-cycle counter; a flushed cycle is not a stall cycle
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (stall_s && !FLUSH && (cnt_r != CNT_MAX)) begin
      cnt_r <= cnt_r + CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: tb/tb_otter_hazard_scoreboard.sv
// Scoreboard bench for otter_hazard_scoreboard. Three instances share the
// decode inputs: forwarding mode (id 0), stall-only mode (id 1) and a deep
// stall-only instance with a 2-bit counter (id 2). Each directed cycle pushes
// its hand-computed expectation for one instance; a monitor on the falling
// edge pops and compares it against that instance's outputs.
module tb_otter_hazard_scoreboard;

  logic       CLK = 1'b0;
  logic       RST;
  logic       DEC_VALID;
  logic [4:0] DEC_RS1, DEC_RS2, DEC_RD;
  logic       DEC_USES_RS1, DEC_USES_RS2, DEC_RD_WE, DEC_IS_LOAD, FLUSH;

  logic        stall_f, issue_f;
  logic [1:0]  fa_f, fb_f;
  logic [15:0] cnt_f;
  logic        stall_s, issue_s;
  logic [1:0]  fa_s, fb_s;
  logic [15:0] cnt_s;
  logic        stall_t, issue_t;
  logic [2:0]  fa_t, fb_t;
  logic [1:0]  cnt_t;

  typedef struct {
    int          id;
    string       name;
    logic        stall;
    logic        issue;
    logic [2:0]  sel_a;
    logic [2:0]  sel_b;
    logic [15:0] cnt;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 CLK = ~CLK;

  otter_hazard_scoreboard #(.STAGES(3), .REG_AW(5), .FWD_EN(1), .LOAD_LAT(2), .CNT_W(16)) u_fwd (
    .CLK(CLK), .RST(RST), .DEC_VALID(DEC_VALID), .DEC_RS1(DEC_RS1), .DEC_RS2(DEC_RS2),
    .DEC_USES_RS1(DEC_USES_RS1), .DEC_USES_RS2(DEC_USES_RS2), .DEC_RD(DEC_RD),
    .DEC_RD_WE(DEC_RD_WE), .DEC_IS_LOAD(DEC_IS_LOAD), .FLUSH(FLUSH),
    .STALL(stall_f), .ISSUE(issue_f), .FWD_A_SEL(fa_f), .FWD_B_SEL(fb_f), .STALL_CNT(cnt_f));

  otter_hazard_scoreboard #(.STAGES(3), .REG_AW(5), .FWD_EN(0), .LOAD_LAT(2), .CNT_W(16)) u_stl (
    .CLK(CLK), .RST(RST), .DEC_VALID(DEC_VALID), .DEC_RS1(DEC_RS1), .DEC_RS2(DEC_RS2),
    .DEC_USES_RS1(DEC_USES_RS1), .DEC_USES_RS2(DEC_USES_RS2), .DEC_RD(DEC_RD),
    .DEC_RD_WE(DEC_RD_WE), .DEC_IS_LOAD(DEC_IS_LOAD), .FLUSH(FLUSH),
    .STALL(stall_s), .ISSUE(issue_s), .FWD_A_SEL(fa_s), .FWD_B_SEL(fb_s), .STALL_CNT(cnt_s));

  otter_hazard_scoreboard #(.STAGES(6), .REG_AW(5), .FWD_EN(0), .LOAD_LAT(2), .CNT_W(2)) u_sat (
    .CLK(CLK), .RST(RST), .DEC_VALID(DEC_VALID), .DEC_RS1(DEC_RS1), .DEC_RS2(DEC_RS2),
    .DEC_USES_RS1(DEC_USES_RS1), .DEC_USES_RS2(DEC_USES_RS2), .DEC_RD(DEC_RD),
    .DEC_RD_WE(DEC_RD_WE), .DEC_IS_LOAD(DEC_IS_LOAD), .FLUSH(FLUSH),
    .STALL(stall_t), .ISSUE(issue_t), .FWD_A_SEL(fa_t), .FWD_B_SEL(fb_t), .STALL_CNT(cnt_t));

  // Drive one decode cycle just after the rising edge
  task automatic cyc(input logic rst, input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic u1, input logic u2, input logic [4:0] rd, input logic we,
                     input logic ld, input logic fl);
    @(posedge CLK);
    #1;
    RST = rst; DEC_VALID = v; DEC_RS1 = rs1; DEC_RS2 = rs2;
    DEC_USES_RS1 = u1; DEC_USES_RS2 = u2; DEC_RD = rd; DEC_RD_WE = we;
    DEC_IS_LOAD = ld; FLUSH = fl;
  endtask

  task automatic reset_cycle();
    cyc(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle_cycle();
    cyc(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Queue the expected outputs for the cycle just driven
  task automatic expect_out(input int id, input string nm, input logic st, input logic is,
                            input logic [2:0] a, input logic [2:0] b, input logic [15:0] c);
    exp_t e;
    e.id = id; e.name = nm; e.stall = st; e.issue = is; e.sel_a = a; e.sel_b = b; e.cnt = c;
    q.push_back(e);
  endtask

  exp_t        e_cur;
  logic        g_st, g_is;
  logic [2:0]  g_a, g_b;
  logic [15:0] g_c;

  // Monitor: compare queued expectations against the addressed instance
  always @(negedge CLK) begin
    if (q.size() > 0) begin
      e_cur = q.pop_front();
      case (e_cur.id)
        0: begin g_st = stall_f; g_is = issue_f; g_a = {1'b0, fa_f}; g_b = {1'b0, fb_f}; g_c = cnt_f; end
        1: begin g_st = stall_s; g_is = issue_s; g_a = {1'b0, fa_s}; g_b = {1'b0, fb_s}; g_c = cnt_s; end
        default: begin g_st = stall_t; g_is = issue_t; g_a = fa_t; g_b = fb_t; g_c = {14'd0, cnt_t}; end
      endcase
      n_cmp++;
      if ((g_st !== e_cur.stall) || (g_is !== e_cur.issue) || (g_a !== e_cur.sel_a) ||
          (g_b !== e_cur.sel_b) || (g_c !== e_cur.cnt)) begin
        n_bad++;
        $display("FAIL %s: got stall=%0b issue=%0b a=%0d b=%0d cnt=%0d, want stall=%0b issue=%0b a=%0d b=%0d cnt=%0d",
                 e_cur.name, g_st, g_is, g_a, g_b, g_c,
                 e_cur.stall, e_cur.issue, e_cur.sel_a, e_cur.sel_b, e_cur.cnt);
      end
    end
  end

  initial begin
    RST = 1'b1; DEC_VALID = 1'b0; DEC_RS1 = 5'd0; DEC_RS2 = 5'd0; DEC_RD = 5'd0;
    DEC_USES_RS1 = 1'b0; DEC_USES_RS2 = 1'b0; DEC_RD_WE = 1'b0; DEC_IS_LOAD = 1'b0; FLUSH = 1'b0;

    // ALU forwarding chain
    reset_cycle();
    cyc(1'b0, 1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    expect_out(0, "fwd_reset_add_x5", 1'b0, 1'b1, 3'd0, 3'd0, 16'd0);
    cyc(1'b0, 1'b1, 5'd5, 5'd1, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
    expect_out(0, "fwd_sub_x6_x5", 1'b0, 1'b1, 3'd1, 3'd0, 16'd0);
    cyc(1'b0, 1'b1, 5'd5, 5'd0, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
    expect_out(0, "fwd_x5_from_e1", 1'b0, 1'b1, 3'd2, 3'd0, 16'd0);
    cyc(1'b0, 1'b1, 5'd6, 5'd5, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0);
    expect_out(0, "fwd_x6_e1_x5_e2", 1'b0, 1'b1, 3'd2, 3'd3, 16'd0);

    // Load to x0 followed by a reader of x0 never stalls
    reset_cycle();
    cyc(1'b0, 1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
    expect_out(0, "fwd_lw_x0", 1'b0, 1'b1, 3'd0, 3'd0, 16'd0);
    cyc(1'b0, 1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd11, 1'b1, 1'b0, 1'b0);
    expect_out(0, "fwd_read_x0", 1'b0, 1'b1, 3'd0, 3'd0, 16'd0);

    // Load-use: two stall cycles then forward from writeback
    reset_cycle();
    cyc(1'b0, 1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0);
    expect_out(0, "ld_issue_lw_x7", 1'b0, 1'b1, 3'd0, 3'd0, 16'd0);
    cyc(1'b0, 1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
    expect_out(0, "ld_stall_e0", 1'b1, 1'b0, 3'd1, 3'd1, 16'd0);
    cyc(1'b0, 1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
    expect_out(0, "ld_stall_e1", 1'b1, 1'b0, 3'd2, 3'd2, 16'd1);
    cyc(1'b0, 1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
    expect_out(0, "ld_fwd_e2", 1'b0, 1'b1, 3'd3, 3'd3, 16'd2);
    idle_cycle();
    expect_out(0, "ld_cnt_after", 1'b0, 1'b0, 3'd0, 3'd0, 16'd2);

    // Flush while stalled on a load
    reset_cycle();
    cyc(1'b0, 1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0);
    expect_out(0, "fl_issue_lw_x7", 1'b0, 1'b1, 3'd0, 3'd0, 16'd0);
    cyc(1'b0, 1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b1);
    expect_out(0, "fl_stall_flush", 1'b1, 1'b0, 3'd1, 3'd1, 16'd0);
    idle_cycle();
    expect_out(0, "fl_idle_no_stall", 1'b0, 1'b0, 3'd0, 3'd0, 16'd0);
    cyc(1'b0, 1'b1, 5'd8, 5'd7, 1'b1, 1'b1, 5'd12, 1'b1, 1'b0, 1'b0);
    expect_out(0, "fl_bubble_check", 1'b0, 1'b1, 3'd0, 3'd3, 16'd0);

    // Stall-only mode: producer/consumer through writeback
    reset_cycle();
    cyc(1'b0, 1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
    expect_out(1, "so_reset_add_x3", 1'b0, 1'b1, 3'd0, 3'd0, 16'd0);
    cyc(1'b0, 1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);
    expect_out(1, "so_stall_e0", 1'b1, 1'b0, 3'd0, 3'd0, 16'd0);
    cyc(1'b0, 1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);
    expect_out(1, "so_stall_e1", 1'b1, 1'b0, 3'd0, 3'd0, 16'd1);
    cyc(1'b0, 1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);
    expect_out(1, "so_stall_wb", 1'b1, 1'b0, 3'd0, 3'd0, 16'd2);
    cyc(1'b0, 1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);
    expect_out(1, "so_issue", 1'b0, 1'b1, 3'd0, 3'd0, 16'd3);
    cyc(1'b0, 1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
    expect_out(1, "so_write_x0", 1'b0, 1'b1, 3'd0, 3'd0, 16'd3);
    cyc(1'b0, 1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd13, 1'b1, 1'b0, 1'b0);
    expect_out(1, "so_read_x0", 1'b0, 1'b1, 3'd0, 3'd0, 16'd3);

    // Counter saturation on a 2-bit counter, then reset mid-stall
    reset_cycle();
    cyc(1'b0, 1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
    expect_out(2, "sat_add_x3", 1'b0, 1'b1, 3'd0, 3'd0, 16'd0);
    cyc(1'b0, 1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);
    expect_out(2, "sat_stall_cnt0", 1'b1, 1'b0, 3'd0, 3'd0, 16'd0);
    for (int i = 1; i <= 5; i++) begin
      cyc((i == 5) ? 1'b1 : 1'b0, 1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);
      expect_out(2, $sformatf("sat_stall_%0d", i), 1'b1, 1'b0, 3'd0, 3'd0,
                 (i >= 3) ? 16'd3 : 16'(i));
    end
    cyc(1'b0, 1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);
    expect_out(2, "sat_after_reset", 1'b0, 1'b1, 3'd0, 3'd0, 16'd0);

    idle_cycle();
    // Bounded drain of the expectation queue
    for (int w = 0; w < 10 && q.size() > 0; w++) begin
      @(posedge CLK);
    end
    if (q.size() > 0) begin
      n_bad++;
      $display("FAIL drain_timeout: %0d expectations left, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
